arb4_rr: RTL

Four-requester round-robin bus arbiter that schedules a shared resource selected through a 2-to-4 active-low decoder. Requesters raise active-low requests; the arbiter grants one at a time. It holds the grant until the owner releases, then rotates priority. It drives both the decoded one-hot active-low grants and the encoded enable/select lines for an external 2-to-4 decoder stage (chip-select style).

---
 rtl/arb4_rr_pkg.sv | 30 +++
 rtl/arb4_rr_if.sv | 28 ++
 rtl/arb4_rr_dec24.sv | 15 +
 rtl/arb4_rr.sv | 98 +++++++++
 4 files changed

// File: rtl/arb4_rr_pkg.sv
// Shared definitions for the arb4_rr round-robin arbiter: state encodings,
// reset pointer, hold-counter width and the rotating-priority pick function.
package arb4_rr_pkg;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_t;

  // LAST resets to 3 so requester 0 is scanned first after reset.
  localparam logic [1:0] LAST_RST = 2'd3;
  localparam int         HCNT_W   = 8;

  // First set bit of elig scanning last+1, last+2, last+3, last (mod 4).
  function automatic logic [1:0] rr_pick(input logic [3:0] elig,
                                         input logic [1:0] last);
    logic [1:0] idx;
    logic       found;
    rr_pick = last;
    found   = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = last + 2'(k);
      if (!found && elig[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/arb4_rr_if.sv
// Bus-side signal bundle of arb4_rr: active-low requests in, one-hot grant and
// decoder enable/select lines out, plus status and FSM debug state.
interface arb4_rr_if;
  import arb4_rr_pkg::*;

  // Handshake: requester i holds REQ_L[i] low (valid) for as long as it needs
  // the resource; GNT_L[i] low (ready/ownership) marks the cycles it owns it.
  // Transfers happen while both are low; raising REQ_L[i] releases the grant.
  logic [3:0] REQ_L;
  logic [3:0] GNT_L;
  logic       DEC_G_L;
  logic       DEC_A;
  logic       DEC_B;
  logic       BUSY;
  logic       TO_PULSE;
  arb_state_t DBG_STATE;

  modport master (
    output REQ_L,
    input  GNT_L, DEC_G_L, DEC_A, DEC_B, BUSY, TO_PULSE, DBG_STATE
  );

  modport slave (
    input  REQ_L,
    output GNT_L, DEC_G_L, DEC_A, DEC_B, BUSY, TO_PULSE, DBG_STATE
  );

endinterface

// File: rtl/arb4_rr_dec24.sv
// arb4_dec24: combinational 2-to-4 active-low decoder (74x139 style half).
// Y_L[{A,B}] is low only while the enable G_L is low.
module arb4_dec24 (
  input  logic       G_L,
  input  logic       A,
  input  logic       B,
  output logic [3:0] Y_L
);

  always_comb begin
    Y_L = 4'b1111;
    if (!G_L) Y_L[{A, B}] = 1'b0;
  end

endmodule

// File: rtl/arb4_rr.sv
// arb4_rr: four-requester round-robin arbiter driving one-hot active-low grants
// and 2-to-4 decoder lines. Optional grant timeout: define ARB_TIMEOUT_EN.
module arb4_rr
  import arb4_rr_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic      CLK,
  input  logic      RESET,
  arb4_rr_if.slave  bus
);

  if (MAX_HOLD < 2 || MAX_HOLD > (1 << HCNT_W) - 1) begin : g_bad_hold
    $error("arb4_rr: MAX_HOLD out of range");
  end

  arb_state_t r_state;
  logic [1:0] r_own;
  logic [1:0] r_last;
  logic [3:0] w_lock;
  logic [3:0] w_elig;
  logic [1:0] w_win;
  logic       w_busy;
  logic       w_timeout;

  assign w_elig = ~bus.REQ_L & ~w_lock;
  assign w_win  = rr_pick(w_elig, r_last);
  assign w_busy = (r_state == ARB_GRANT);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= ARB_IDLE;
      r_own   <= 2'd0;
      r_last  <= LAST_RST;
    end else begin
      case (r_state)
        ARB_IDLE: begin
          if (|w_elig) begin
            r_own   <= w_win;
            r_last  <= w_win;
            r_state <= ARB_GRANT;
          end
        end
        ARB_GRANT: begin
          // Release takes precedence; either way the next cycle is turnaround.
          if (bus.REQ_L[r_own] || w_timeout) r_state <= ARB_IDLE;
        end
        default: r_state <= ARB_IDLE;
      endcase
    end
  end

`ifdef ARB_TIMEOUT_EN
  logic [HCNT_W-1:0] r_hcnt;
  logic [3:0]        r_lock;
  logic              r_to_pulse;

  assign w_timeout = w_busy && !bus.REQ_L[r_own] &&
                     (r_hcnt == HCNT_W'(MAX_HOLD - 1));
  assign w_lock    = r_lock;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_hcnt     <= '0;
      r_lock     <= '0;
      r_to_pulse <= 1'b0;
    end else begin
      // A lock only falls away once its requester has been seen released.
      r_lock     <= r_lock & ~bus.REQ_L;
      r_to_pulse <= w_timeout;
      if (w_timeout) r_lock[r_own] <= 1'b1;
      if (!w_busy) r_hcnt <= '0;
      else if (r_hcnt != '1) r_hcnt <= r_hcnt + 1'b1;
    end
  end

  assign bus.TO_PULSE = r_to_pulse;
`else
  assign w_timeout    = 1'b0;
  assign w_lock       = 4'b0000;
  assign bus.TO_PULSE = 1'b0;
`endif

  assign bus.BUSY      = w_busy;
  assign bus.DEC_G_L   = ~w_busy;
  assign bus.DEC_A     = w_busy & r_own[1];
  assign bus.DEC_B     = w_busy & r_own[0];
  assign bus.DBG_STATE = r_state;

  // Grants come from the decoder lines so the two can never disagree.
  arb4_dec24 u_dec (
    .G_L (bus.DEC_G_L),
    .A   (bus.DEC_A),
    .B   (bus.DEC_B),
    .Y_L (bus.GNT_L)
  );

endmodule
